// File: rtl/mha_pkg.sv
// Shared definitions for the MHA stages: scheduler state encoding,
// address map defaults and a counter-width helper.
package mha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_Q   = 3'd1,
    ST_STREAM_K = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } mha_state_e;

  localparam int unsigned MHA_Q_BASE      = 32'h0000_0000;
  localparam int unsigned MHA_K_BASE      = 32'h0000_3000;
  localparam int unsigned MHA_BANK_STRIDE = 32'h0000_0300;

  // $clog2 of 1 is 0; counters always need at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_addr_gen.sv
// Expands one token counter into per-bank addresses:
// slice gi = BASE + gi*STRIDE + counter, all at ADDR_W bits.
module bank_addr_gen #(
  parameter int          N_BANK = 16,
  parameter int          ADDR_W = 32,
  parameter int          CNT_W  = 10,
  parameter int unsigned BASE   = 32'h0,
  parameter int unsigned STRIDE = 32'h300
) (
  input  logic [CNT_W-1:0]         i_cnt,
  output logic [N_BANK*ADDR_W-1:0] o_addr_bus
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BANK; gi++) begin : g_bank
      localparam logic [ADDR_W-1:0] SLICE_BASE = ADDR_W'(BASE + gi * STRIDE);
      assign o_addr_bus[gi*ADDR_W +: ADDR_W] = SLICE_BASE + ADDR_W'(i_cnt);
    end
  endgenerate

endmodule

// File: rtl/qk_score_sched.sv
// QK score read scheduler: for each query row, one Q read followed by a
// stream of N_TOK K reads, then a fixed drain before signalling done.
module qk_score_sched
  import mha_pkg::*;
#(
  parameter int          N_TOK       = 729,
  parameter int          N_BANK      = 16,
  parameter int          ADDR_W      = 32,
  parameter int unsigned Q_BASE      = MHA_Q_BASE,
  parameter int unsigned K_BASE      = MHA_K_BASE,
  parameter int unsigned BANK_STRIDE = MHA_BANK_STRIDE,
  parameter int          PIPE_LAT    = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     ready,
  output logic                     busy,
  output logic                     q_rd_en,
  output logic [N_BANK*ADDR_W-1:0] q_addr_bus,
  output logic                     k_rd_en,
  output logic [N_BANK*ADDR_W-1:0] k_addr_bus,
  output logic                     row_first,
  output logic                     row_last,
  output logic                     done
);

  localparam int CNT_W = cnt_width(N_TOK);
  localparam int DR_W  = cnt_width(PIPE_LAT);
  localparam logic [CNT_W-1:0] LAST_TOK = CNT_W'(N_TOK - 1);
  localparam logic [DR_W-1:0]  LAST_DR  = DR_W'(PIPE_LAT - 1);

  mha_state_e       r_state;
  logic [CNT_W-1:0] r_i;
  logic [CNT_W-1:0] r_j;
  logic [DR_W-1:0]  r_drain;
  logic             r_busy;
  logic             r_q_rd_en;
  logic             r_done;
  logic             w_k_rd_en;

  // K reads fire in the same cycle the array is ready, so this stays combinational.
  assign w_k_rd_en = (r_state == ST_STREAM_K) && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_q_rd_en <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_LOAD_Q;
            r_i       <= '0;
            r_j       <= '0;
            r_drain   <= '0;
            r_busy    <= 1'b1;
            r_q_rd_en <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_LOAD_Q: begin
          r_state   <= ST_STREAM_K;
          r_q_rd_en <= 1'b0;
        end
        ST_STREAM_K: begin
          if (w_k_rd_en) begin
            if (r_j == LAST_TOK) begin
              r_j <= '0;
              if (r_i != LAST_TOK) begin
                r_i       <= r_i + CNT_W'(1);
                r_state   <= ST_LOAD_Q;
                r_q_rd_en <= 1'b1;
              end else begin
                r_state <= ST_DRAIN;
                r_drain <= '0;
              end
            end else begin
              r_j <= r_j + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain == LAST_DR) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + DR_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_q_rd_en <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign q_rd_en   = r_q_rd_en;
  assign done      = r_done;
  assign k_rd_en   = w_k_rd_en;
  assign row_first = w_k_rd_en && (r_j == '0);
  assign row_last  = w_k_rd_en && (r_j == LAST_TOK);

  bank_addr_gen #(
    .N_BANK (N_BANK),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .BASE   (Q_BASE),
    .STRIDE (BANK_STRIDE)
  ) u_q_addr (
    .i_cnt      (r_i),
    .o_addr_bus (q_addr_bus)
  );

  bank_addr_gen #(
    .N_BANK (N_BANK),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .BASE   (K_BASE),
    .STRIDE (BANK_STRIDE)
  ) u_k_addr (
    .i_cnt      (r_j),
    .o_addr_bus (k_addr_bus)
  );

endmodule
